// File: rtl/sync_fifo_if.sv
// Push/pop/full/empty FIFO interface shared by the FIFO and its users.
interface sync_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             push;
  logic [WIDTH-1:0] wdata;
  logic             pop;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  // Producer/consumer side: issues requests, observes status.
  modport master (
    output push, wdata, pop,
    input  rdata, full, empty, count, overflow, underflow
  );

  // FIFO side: accepts requests, drives status and head data.
  modport slave (
    input  push, wdata, pop,
    output rdata, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and sticky
// overflow/underflow flags. Requests are judged against registered
// status only, so an illegal request never disturbs stored state.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full_q;
  logic             empty_q;
  logic             ovf_q;
  logic             unf_q;
  logic             push_ok;
  logic             pop_ok;

  // Accept decisions and next occupancy from registered flags only.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    cnt_nxt = cnt;
    push_ok = bus.push & ~full_q;
    pop_ok  = bus.pop & ~empty_q;
    if (push_ok && !pop_ok) begin
      cnt_nxt = cnt + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Pointers, occupancy, status flags and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + AW'(1);
      end
      if (pop_ok) begin
        rp <= rp + AW'(1);
      end
      cnt     <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(DEPTH));
      empty_q <= (cnt_nxt == '0);
      if (bus.push && full_q) begin
        ovf_q <= 1'b1;
      end
      if (bus.pop && empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  // Storage write; not cleared by reset, but reset blocks a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wp] <= bus.wdata;
    end
  end

  assign bus.rdata     = mem[rp];
  assign bus.count     = cnt;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, WIDTH=8) with hand-computed expectations.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] q [$];
  logic [7:0] d;

  sync_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  sync_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.wdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_unf", 32'(bus.underflow), 0);

    // Fill with 0x11..0x44
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      bus.push  = 1'b1;
      bus.wdata = d;
      tick();
      q.push_back(d);
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_empty", 32'(bus.empty), 0);
      check("fill_full", 32'(bus.full), (i == 3) ? 1 : 0);
      check("fill_rdata", 32'(bus.rdata), 32'h11);
    end

    // Overflow: push while full is rejected and flagged
    bus.wdata = 8'h55;
    tick();
    bus.push = 1'b0;
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_unf_clear", 32'(bus.underflow), 0);
    tick();
    check("ovf_sticky", 32'(bus.overflow), 1);

    // Drain: only the four accepted words come out
    for (int i = 0; i < 4; i++) begin
      check("drain_rdata", 32'(bus.rdata), 32'(q[0]));
      bus.pop = 1'b1;
      tick();
      void'(q.pop_front());
      check("drain_count", 32'(bus.count), 32'(3 - i));
      check("drain_full", 32'(bus.full), 0);
    end
    bus.pop = 1'b0;
    check("drain_empty", 32'(bus.empty), 1);

    // Underflow with concurrent push: pop rejected, push accepted
    bus.push  = 1'b1;
    bus.pop   = 1'b1;
    bus.wdata = 8'hA5;
    tick();
    q.push_back(8'hA5);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check("unf_flag", 32'(bus.underflow), 1);
    check("unf_count", 32'(bus.count), 1);
    check("unf_empty", 32'(bus.empty), 0);
    check("unf_rdata", 32'(bus.rdata), 32'hA5);

    // Bring count to 2, then stream push+pop for 10 cycles across the wrap
    bus.push  = 1'b1;
    bus.wdata = 8'h01;
    tick();
    q.push_back(8'h01);
    check("pre_stream_count", 32'(bus.count), 2);
    bus.pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'(i + 2);
      bus.wdata = d;
      check("stream_rdata", 32'(bus.rdata), 32'(q[0]));
      tick();
      void'(q.pop_front());
      q.push_back(d);
      check("stream_count", 32'(bus.count), 2);
      check("stream_full", 32'(bus.full), 0);
      check("stream_empty", 32'(bus.empty), 0);
    end
    bus.pop = 1'b0;
    check("post_stream_rdata", 32'(bus.rdata), 32'(q[0]));

    // Fill to full (two more words)
    for (int i = 0; i < 2; i++) begin
      d = 8'(8'hC0 + i);
      bus.wdata = d;
      tick();
      q.push_back(d);
    end
    bus.push = 1'b0;
    check("refill_count", 32'(bus.count), 4);
    check("refill_full", 32'(bus.full), 1);

    // Full with simultaneous push and pop: pop wins, push rejected
    bus.push  = 1'b1;
    bus.pop   = 1'b1;
    bus.wdata = 8'h99;
    tick();
    void'(q.pop_front());
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check("fullpp_count", 32'(bus.count), 3);
    check("fullpp_full", 32'(bus.full), 0);
    check("fullpp_ovf", 32'(bus.overflow), 1);
    check("fullpp_rdata", 32'(bus.rdata), 32'(q[0]));

    // Reset mid-operation with a concurrent push
    rst       = 1'b1;
    bus.push  = 1'b1;
    bus.wdata = 8'h77;
    tick();
    rst      = 1'b0;
    bus.push = 1'b0;
    q.delete();
    check("mrst_count", 32'(bus.count), 0);
    check("mrst_empty", 32'(bus.empty), 1);
    check("mrst_full", 32'(bus.full), 0);
    check("mrst_ovf", 32'(bus.overflow), 0);
    check("mrst_unf", 32'(bus.underflow), 0);
    tick();
    check("mrst_discard", 32'(bus.count), 0);

    // Fresh traffic after reset starts from slot 0
    bus.push  = 1'b1;
    bus.wdata = 8'h3C;
    tick();
    bus.push = 1'b0;
    check("post_rst_rdata", 32'(bus.rdata), 32'h3C);
    check("post_rst_count", 32'(bus.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
